sme_job_sched: RTL and testbench

SME_JOB_SCHED -- requirements
Module: sme_job_sched

---
 rtl/sme_job_sched.sv | 153 +++++++++++++++
 tb/tb_sme_job_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_job_sched.sv
// Two-requester job scheduler feeding a string-matching engine (SME): arbitrates string and
// pattern segments, streams bytes to the SME with length limits, and returns one result per pattern job.
module sme_job_sched #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] kind,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       last0,
    input  logic       last1,
    output logic [1:0] gnt,
    output logic       take,
    output logic [7:0] sme_chardata,
    output logic       sme_isstring,
    output logic       sme_ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_match_index,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_id,
    output logic       res_match,
    output logic       res_err,
    output logic [4:0] res_index
);

    localparam int CNT_W = $clog2(STR_MAX + PAT_MAX + 2) + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] STR_MAX_C = CNT_W'(STR_MAX);
    localparam logic [CNT_W-1:0] PAT_MAX_C = CNT_W'(PAT_MAX);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, STR, PAT, DRAIN, WAIT, RESP} state_t;

    state_t           state, state_nx;
    logic             rr_ptr, cur, owner, owner_vld;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic [TMR_W-1:0] tmr;
    logic             sel, cur_last, grant;
    logic [7:0]       cur_byte;
    logic             fwd_str, fwd_pat, str_end, load_err, load_sme;

    // Long segments keep being consumed, so the byte count must not wrap back into range.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        sel      = req[rr_ptr] ? rr_ptr : ~rr_ptr;
        cur_byte = cur ? data1 : data0;
        cur_last = cur ? last1 : last0;
        cnt_inc  = sat_inc(cnt);
        take     = (state == STR) || (state == PAT) || (state == DRAIN);
        grant    = (state == IDLE) && (|req);
        fwd_str  = (state == STR) && (cnt_inc <= STR_MAX_C);
        fwd_pat  = (state == PAT) && (cnt_inc <= PAT_MAX_C);
        str_end  = (state == STR) && cur_last;
        load_sme = (state == WAIT) && sme_valid;
        load_err = (take && cur_last && ((state == DRAIN) || ((state == PAT) && (cnt_inc > PAT_MAX_C))))
                 || ((state == WAIT) && !sme_valid && (tmr == TMR_LAST));
        case (state)
            IDLE: begin
                if (grant) begin
                    if (!kind[sel])                          state_nx = STR;
                    else if (owner_vld && (owner == sel))    state_nx = PAT;
                    else                                     state_nx = DRAIN;
                end
            end
            STR:     if (cur_last) state_nx = IDLE;
            PAT:     if (cur_last) state_nx = (cnt_inc > PAT_MAX_C) ? RESP : WAIT;
            DRAIN:   if (cur_last) state_nx = RESP;
            WAIT:    if (sme_valid || (tmr == TMR_LAST)) state_nx = RESP;
            RESP:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign res_valid = (state == RESP);

    // Stage boundary: grant, byte forwarding and result capture all register on this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt           <= '0;
            cur           <= 1'b0;
            rr_ptr        <= 1'b0;
            owner         <= 1'b0;
            owner_vld     <= 1'b0;
            cnt           <= '0;
            tmr           <= '0;
            sme_chardata  <= '0;
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
            res_id        <= 1'b0;
            res_match     <= 1'b0;
            res_err       <= 1'b0;
            res_index     <= '0;
        end else begin
            sme_isstring  <= 1'b0;
            sme_ispattern <= 1'b0;
            if (grant) begin
                gnt    <= sel ? 2'b10 : 2'b01;
                cur    <= sel;
                rr_ptr <= ~sel;
                cnt    <= '0;
            end
            if (take) begin
                cnt <= cnt_inc;
                if (fwd_str) begin
                    sme_chardata <= cur_byte;
                    sme_isstring <= 1'b1;
                end
                if (fwd_pat) begin
                    sme_chardata  <= cur_byte;
                    sme_ispattern <= 1'b1;
                end
                if (cur_last) begin
                    gnt <= '0;
                    cnt <= '0;
                    tmr <= '0;
                    if (state != STR) res_id <= cur;
                end
                // A truncated string cannot anchor a later pattern.
                if (str_end) begin
                    owner     <= cur;
                    owner_vld <= (cnt_inc <= STR_MAX_C);
                end
            end
            if (state == WAIT) tmr <= tmr + 1'b1;
            if (load_err) begin
                res_match <= 1'b0;
                res_err   <= 1'b1;
                res_index <= '0;
            end
            if (load_sme) begin
                res_match <= sme_match;
                res_err   <= 1'b0;
                res_index <= sme_match ? sme_match_index : 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_sme_job_sched.sv
// Randomized scoreboard bench for sme_job_sched with a job-level reference model.
module tb_sme_job_sched;
    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = '0, kind = '0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       last0 = 1'b0, last1 = 1'b0;
    logic [1:0] gnt;
    logic       take;
    logic [7:0] sme_chardata;
    logic       sme_isstring, sme_ispattern;
    logic       sme_valid, sme_drv = 1'b0, sme_noise = 1'b0, sme_match = 1'b0;
    logic [4:0] sme_match_index = '0;
    logic       res_valid, res_ready = 1'b0, res_id, res_match, res_err;
    logic [4:0] res_index;

    always #5 clk = ~clk;
    assign sme_valid = sme_drv | sme_noise;

    sme_job_sched #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .kind(kind), .data0(data0), .data1(data1),
        .last0(last0), .last1(last1), .gnt(gnt), .take(take), .sme_chardata(sme_chardata),
        .sme_isstring(sme_isstring), .sme_ispattern(sme_ispattern), .sme_valid(sme_valid),
        .sme_match(sme_match), .sme_match_index(sme_match_index), .res_valid(res_valid),
        .res_ready(res_ready), .res_id(res_id), .res_match(res_match), .res_err(res_err),
        .res_index(res_index));

    int n_chk = 0, n_pass = 0;
    int n_str = 0, n_pat = 0, n_take = 0;
    logic [8:0] exp_b[$];   // {is_pattern, byte}
    logic [7:0] exp_r[$];   // {id, match, err, index}
    logic [7:0] sb0[$], sb1[$];
    logic [8:0] eb;
    logic [7:0] er;
    bit m_owner = 1'b0, m_ovld = 1'b0;
    bit rdy_rand = 1'b0, rdy_val = 1'b1, noise_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [7:0] getb(input int r, input int i);
        return (r != 0) ? sb1[i] : sb0[i];
    endfunction

    function automatic int seglen(input int r);
        return (r != 0) ? sb1.size() : sb0.size();
    endfunction

    task automatic fill(input int r, input int len);
        if (r != 0) sb1.delete(); else sb0.delete();
        for (int i = 0; i < len; i++) begin
            if (r != 0) sb1.push_back(8'($urandom)); else sb0.push_back(8'($urandom));
        end
    endtask

    // Reference model: what a whole job should produce, from the scheduling rules alone.
    function automatic bit model_job(input int r, input bit k);
        int len = seglen(r);
        if (!k) begin
            for (int i = 0; i < len && i < STR_MAX; i++) exp_b.push_back({1'b0, getb(r, i)});
            m_owner = bit'(r);
            m_ovld  = (len <= STR_MAX);
            return 1'b0;
        end
        if (!(m_ovld && m_owner == bit'(r))) begin
            exp_r.push_back({bit'(r), 1'b0, 1'b1, 5'd0});
            return 1'b0;
        end
        for (int i = 0; i < len && i < PAT_MAX; i++) exp_b.push_back({1'b1, getb(r, i)});
        if (len > PAT_MAX) begin
            exp_r.push_back({bit'(r), 1'b0, 1'b1, 5'd0});
            return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive(input int r, input int i, input int len);
        if (r != 0) begin data1 = sb1[i]; last1 = (i == len - 1); end
        else        begin data0 = sb0[i]; last0 = (i == len - 1); end
    endtask

    task automatic send(input int r, input bit k);
        int len = seglen(r);
        int i = 0;
        int guard = 0;
        kind[r] = k;
        drive(r, 0, len);
        req[r] = 1'b1;
        while (i < len) begin
            @(negedge clk);
            guard++;
            if (guard > 400) begin
                chk($sformatf("send_bytes_taken_r%0d", r), i, len);
                req[r] = 1'b0;
                return;
            end
            if (take && gnt[r]) begin
                @(posedge clk); #1;
                i++;
                if (i < len) drive(r, i, len);
                else req[r] = 1'b0;
            end
        end
    endtask

    task automatic sme_reply(input int r, input bit tmo, input bit m, input logic [4:0] idx, input int lat);
        if (tmo) begin
            exp_r.push_back({bit'(r), 1'b0, 1'b1, 5'd0});
            return;
        end
        exp_r.push_back({bit'(r), m, 1'b0, m ? idx : 5'd0});
        repeat (lat) begin @(posedge clk); #1; end
        sme_match = m;
        sme_match_index = idx;
        sme_drv = 1'b1;
        @(posedge clk); #1;
        sme_drv = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && g < TIMEOUT + 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= TIMEOUT + 500) chk("wait_done_pending_results", exp_r.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_res(output int k);
        k = 0;
        while (k < TIMEOUT + 20) begin
            @(negedge clk);
            k++;
            if (res_valid) break;
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        req = '0;
        sme_drv = 1'b0;
        noise_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_take"}, take, 0);
        chk({tag, "_strobes"}, {sme_isstring, sme_ispattern}, 0);
        chk({tag, "_chardata"}, sme_chardata, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_fields"}, {res_id, res_match, res_err, res_index}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_ovld = 1'b0;
        m_owner = 1'b0;
        exp_b.delete();
        exp_r.delete();
    endtask

    always @(posedge clk) begin
        #1;
        res_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_val;
        sme_noise = noise_en && ($urandom_range(0, 3) == 0);
    end

    // Monitor: forwarded bytes and results are compared against the scoreboard queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (take) n_take++;
            if (sme_isstring || sme_ispattern) begin
                chk("strobes_exclusive", sme_isstring & sme_ispattern, 0);
                if (sme_isstring) n_str++; else n_pat++;
                chk("strobe_expected", int'(exp_b.size() != 0), 1);
                if (exp_b.size() != 0) begin
                    eb = exp_b.pop_front();
                    chk("fwd_byte", {sme_ispattern, sme_chardata}, eb);
                end
            end
            if (res_valid && res_ready) begin
                chk("result_expected", int'(exp_r.size() != 0), 1);
                if (exp_r.size() != 0) begin
                    er = exp_r.pop_front();
                    chk("result", {res_id, res_match, res_err, res_index}, er);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, s0, p0, t0, r, len;
        bit kk, need;
        logic [7:0] cap;

        do_reset("reset");

        // String "abcd" then pattern "bc" answered with match at index 1.
        s0 = n_str; p0 = n_pat;
        sb0 = '{8'h61, 8'h62, 8'h63, 8'h64};
        need = model_job(0, 1'b0);
        send(0, 1'b0);
        sb0 = '{8'h62, 8'h63};
        need = model_job(0, 1'b1);
        chk("abcd_pattern_goes_to_sme", need, 1);
        send(0, 1'b1);
        sme_reply(0, 1'b0, 1'b1, 5'd1, 3);
        wait_done();
        chk("abcd_isstring_cycles", n_str - s0, 4);
        chk("bc_ispattern_cycles", n_pat - p0, 2);

        // Pattern from a non-owner is drained.
        s0 = n_str + n_pat; t0 = n_take;
        fill(1, 3);
        need = model_job(1, 1'b1);
        send(1, 1'b1);
        wait_done();
        chk("drain_takes", n_take - t0, 3);
        chk("drain_no_strobes", n_str + n_pat - s0, 0);

        // Overlong pattern: 8 forwarded, 10 taken, error without waiting.
        p0 = n_pat; t0 = n_take;
        fill(0, 10);
        need = model_job(0, 1'b1);
        send(0, 1'b1);
        wait_res(k);
        chk("pat_overflow_latency", k, 1);
        wait_done();
        chk("pat_overflow_takes", n_take - t0, 10);
        chk("pat_overflow_forwarded", n_pat - p0, 8);

        // SME silent: error result exactly TIMEOUT cycles into WAIT.
        fill(0, 3);
        need = model_job(0, 1'b1);
        send(0, 1'b1);
        sme_reply(0, 1'b1, 1'b0, 5'd0, 0);
        wait_res(k);
        chk("timeout_latency", k, TIMEOUT + 1);
        wait_done();

        // Result held under backpressure; pending request not granted meanwhile.
        rdy_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fill(1, 3);
        need = model_job(1, 1'b1);
        send(1, 1'b1);
        fill(0, 5);
        need = model_job(0, 1'b0);
        kind[0] = 1'b0; data0 = sb0[0]; last0 = 1'b0; req[0] = 1'b1;
        wait_res(k);
        cap = {res_id, res_match, res_err, res_index};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_fields_stable", {res_valid, res_id, res_match, res_err, res_index}, {1'b1, cap});
            chk("stall_no_gnt", gnt, 0);
        end
        rdy_val = 1'b1;
        send(0, 1'b0);
        wait_done();

        // Randomized jobs with random backpressure, SME latency and stray sme_valid.
        rdy_rand = 1'b1;
        for (int j = 0; j < 60; j++) begin
            r = $urandom_range(0, 1);
            kk = bit'($urandom_range(0, 1));
            len = kk ? $urandom_range(1, 12) : $urandom_range(1, 40);
            fill(r, len);
            need = model_job(r, kk);
            noise_en = !need;
            send(r, kk);
            noise_en = 1'b0;
            if (need) sme_reply(r, $urandom_range(0, 9) == 0, bit'($urandom_range(0, 1)),
                                5'($urandom), $urandom_range(0, 20));
            wait_done();
        end
        rdy_rand = 1'b0;
        rdy_val = 1'b1;
        @(posedge clk); #1;

        // Reset in the middle of WAIT aborts the job with no result.
        fill(0, 4);
        need = model_job(0, 1'b0);
        send(0, 1'b0);
        fill(0, 2);
        need = model_job(0, 1'b1);
        send(0, 1'b1);
        repeat (5) @(posedge clk);
        do_reset("reset_mid_wait");
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid || gnt != 0) k++;
        end
        chk("no_result_after_abort", k, 0);

        // Simultaneous string requests after reset: requester 0 first, then 1 becomes owner.
        do_reset("reset2");
        fill(0, 3);
        fill(1, 4);
        need = model_job(0, 1'b0);
        need = model_job(1, 1'b0);
        fork
            send(0, 1'b0);
            send(1, 1'b0);
            begin
                int g = 0;
                while (gnt == 0 && g < 50) begin @(negedge clk); g++; end
                chk("first_gnt", gnt, 1);
                while (gnt != 0 && g < 100) begin @(negedge clk); g++; end
                while (gnt == 0 && g < 150) begin @(negedge clk); g++; end
                chk("second_gnt", gnt, 2);
            end
        join
        wait_done();
        fill(1, 2);
        need = model_job(1, 1'b1);
        chk("owner1_pattern_to_sme", need, 1);
        send(1, 1'b1);
        sme_reply(1, 1'b0, 1'b1, 5'd7, 2);
        wait_done();

        chk("leftover_bytes", exp_b.size(), 0);
        chk("leftover_results", exp_r.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
